// File: rtl/stoch_scale.sv
// Stochastic gain stage: scales a unipolar bitstream probability by GAIN using a saturating credit counter.
// Optional macro STOCH_SCALE_CREDIT_OUT_EN exposes the credit register on credit_out.
module stoch_scale #(
  parameter int GAIN        = 2,
  parameter int MAX_CREDIT  = 7,
  parameter int CREDIT_SIZE = $clog2(MAX_CREDIT + GAIN + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  input  logic                   a,
  input  logic                   clear,
  output logic                   out_valid,
  output logic                   y,
`ifdef STOCH_SCALE_CREDIT_OUT_EN
  output logic [CREDIT_SIZE-1:0] credit_out,
`endif
  output logic                   sat
);

  localparam logic [CREDIT_SIZE-1:0] GAIN_W = CREDIT_SIZE'(GAIN);
  localparam logic [CREDIT_SIZE-1:0] MAX_W  = CREDIT_SIZE'(MAX_CREDIT);

  logic [CREDIT_SIZE-1:0] credit;
  logic [CREDIT_SIZE-1:0] sum;
  logic [CREDIT_SIZE-1:0] clipped;
  logic [CREDIT_SIZE-1:0] credit_nxt;
  logic                   over;
  logic                   emit;

  // CREDIT_SIZE is wide enough that credit + GAIN never wraps before the clip.
  always_comb begin
    sum        = credit + (a ? GAIN_W : '0);
    over       = (sum > MAX_W);
    clipped    = over ? MAX_W : sum;
    emit       = (clipped != '0);
    credit_nxt = clipped - CREDIT_SIZE'(emit);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      credit    <= '0;
      sat       <= 1'b0;
      y         <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      credit    <= '0;
      sat       <= 1'b0;
      y         <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      credit    <= credit_nxt;
      if (over) sat <= 1'b1;
      y         <= emit;
      out_valid <= 1'b1;
    end else begin
      // Bubbles hold credit and never produce ones.
      y         <= 1'b0;
      out_valid <= 1'b0;
    end
  end

`ifdef STOCH_SCALE_CREDIT_OUT_EN
  assign credit_out = credit;
`endif

endmodule
